// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - round-robin arbiter sharing one register-file read port
//
// Purpose:
//   Picks at most one of N_REQ requesters per cycle, starting the search at a
//   rotating pointer. The winner's address is registered onto o_read_code; the
//   read-mux output is captured one edge later and returned tagged with the
//   winner's index.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_reset      asynchronous active-high reset
//   i_req        per-requester level request
//   i_addr       packed addresses, requester i uses i_addr[i*AW +: AW]
//   o_read_code  registered select to the register-file read mux
//   i_mux_q      read-mux output for the current o_read_code
//   o_gnt        registered one-hot grant (at most one bit set)
//   o_rvalid     o_rdata / o_rid valid this cycle
//   o_rid        requester index owning o_rdata
//   o_rdata      registered read data
module regfile_read_arbiter #(
  parameter  int N     = 32,
  parameter  int Bits  = 64,
  parameter  int N_REQ = 4,
  localparam int AW    = $clog2(N),
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*AW-1:0]   i_addr,
  output logic [AW-1:0]         o_read_code,
  input  logic [Bits-1:0]       i_mux_q,
  output logic [N_REQ-1:0]      o_gnt,
  output logic                  o_rvalid,
  output logic [IW-1:0]         o_rid,
  output logic [Bits-1:0]       o_rdata
);

  logic [N_REQ-1:0]   r_gnt;
  logic [AW-1:0]      r_read_code;
  logic [IW-1:0]      r_ptr;
  logic               r_pend;
  logic [IW-1:0]      r_pend_id;
  logic               r_rvalid;
  logic [IW-1:0]      r_rid;
  logic [Bits-1:0]    r_rdata;

  logic [N_REQ-1:0]   w_elig;
  logic [2*N_REQ-2:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  logic [IW-1:0]      w_off;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_ptr_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [AW-1:0]      w_addr_win;

  // A requester granted last edge is masked so a held req cannot win twice
  // in a row while the requester is still reacting to its grant.
  assign w_elig = i_req & ~r_gnt;

  // Doubled vector lets the search start at r_ptr without a modulo: bit k of
  // w_rot is the eligibility of requester (r_ptr + k) mod N_REQ.
  assign w_dbl = {w_elig[N_REQ-2:0], w_elig};

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rot[k] = w_dbl[int'(r_ptr) + k];
    end
  end

  // First eligible offset from the pointer.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IW'(k);
      end
    end
  end

  // Winner index = (ptr + offset) mod N_REQ; the extra sum bit covers
  // N_REQ values that are not a power of two.
  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N_REQ)) begin
      w_win = IW'(w_sum - (IW+1)'(N_REQ));
    end else begin
      w_win = IW'(w_sum);
    end
  end

  always_comb begin
    if (w_win == IW'(N_REQ-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_win + IW'(1);
    end
  end

  always_comb begin
    w_gnt_nxt = '0;
    if (w_found) begin
      w_gnt_nxt[w_win] = 1'b1;
    end
  end

  assign w_addr_win = i_addr[w_win*AW +: AW];

  // Grant stage: address is sampled only here, so later addr changes do
  // not disturb the read in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_gnt       <= '0;
      r_read_code <= '0;
      r_ptr       <= '0;
      r_pend      <= 1'b0;
      r_pend_id   <= '0;
    end else begin
      r_pend <= w_found;
      if (w_found) begin
        r_gnt       <= w_gnt_nxt;
        r_read_code <= w_addr_win;
        r_ptr       <= w_ptr_nxt;
        r_pend_id   <= w_win;
      end else begin
        r_gnt <= '0;
      end
    end
  end

  // Capture stage: i_mux_q reflects r_read_code set on the previous edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_pend) begin
        r_rvalid <= 1'b1;
        r_rid    <= r_pend_id;
        r_rdata  <= i_mux_q;
      end else begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_read_code = r_read_code;
  assign o_rvalid    = r_rvalid;
  assign o_rid       = r_rid;
  assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - self-checking bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [19:0] addr;
  logic [4:0]  read_code;
  logic [63:0] mux_q;
  logic [3:0]  gnt;
  logic        rvalid;
  logic [1:0]  rid;
  logic [63:0] rdata;
  logic        mux_dead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_read_arbiter dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       (req),
    .i_addr      (addr),
    .o_read_code (read_code),
    .i_mux_q     (mux_q),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rid       (rid),
    .o_rdata     (rdata)
  );

  function automatic logic [63:0] memval(input logic [4:0] a);
    return {27'd0, a, 32'hAAAA_5555};
  endfunction

  assign mux_q = mux_dead ? 64'hDEAD : memval(read_code);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [4:0]  rc;
    logic        rvalid;
    logic [1:0]  rid;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl[10];

  // Behavioural reference: winner = first requester with req set that was
  // not granted last edge, searched in circular order from the pointer.
  int m_ptr, m_gidx, m_rc, m_pend, m_pend_id, m_rvalid, m_rid;
  logic [63:0] m_rdata;

  task automatic model_init();
    m_ptr = 0; m_gidx = -1; m_rc = 0; m_pend = 0; m_pend_id = 0;
    m_rvalid = 0; m_rid = 0; m_rdata = '0;
  endtask

  task automatic model_edge();
    int w;
    if (reset) begin
      model_init();
    end else begin
      if (m_pend != 0) begin
        m_rvalid = 1; m_rid = m_pend_id; m_rdata = memval(5'(m_rc));
      end else begin
        m_rvalid = 0;
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (w < 0 && req[i] && i != m_gidx) w = i;
      end
      if (w >= 0) begin
        m_gidx = w;
        m_rc = int'((addr >> (5*w)) & 20'h1f);
        m_ptr = (w + 1) % 4;
        m_pend = 1;
        m_pend_id = w;
      end else begin
        m_gidx = -1;
        m_pend = 0;
      end
    end
  endtask

  initial begin
    int cnt[4];
    // addresses {a3,a2,a1,a0} = {30,17,9,5}
    tbl[0] = '{4'b0100, 4'b0100, 5'd17, 1'b0, 2'd0, 64'd0};
    tbl[1] = '{4'b0000, 4'b0000, 5'd17, 1'b1, 2'd2, 64'h0000_0011_AAAA_5555};
    tbl[2] = '{4'b1111, 4'b1000, 5'd30, 1'b0, 2'd2, 64'h0000_0011_AAAA_5555};
    tbl[3] = '{4'b1111, 4'b0001, 5'd5,  1'b1, 2'd3, memval(5'd30)};
    tbl[4] = '{4'b1111, 4'b0010, 5'd9,  1'b1, 2'd0, memval(5'd5)};
    tbl[5] = '{4'b1111, 4'b0100, 5'd17, 1'b1, 2'd1, memval(5'd9)};
    tbl[6] = '{4'b0011, 4'b0001, 5'd5,  1'b1, 2'd2, memval(5'd17)};
    tbl[7] = '{4'b0011, 4'b0010, 5'd9,  1'b1, 2'd0, memval(5'd5)};
    tbl[8] = '{4'b0000, 4'b0000, 5'd9,  1'b1, 2'd1, memval(5'd9)};
    tbl[9] = '{4'b0000, 4'b0000, 5'd9,  1'b0, 2'd1, memval(5'd9)};

    reset = 1'b1; req = '0; addr = {5'd30, 5'd17, 5'd9, 5'd5}; mux_dead = 1'b0;
    step();
    chk("rst_gnt", gnt, 0); chk("rst_rc", read_code, 0); chk("rst_rvalid", rvalid, 0);
    chk("rst_rid", rid, 0); chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Table: single read, round-robin order, wrap-around and skip
    for (int v = 0; v < 10; v++) begin
      req = tbl[v].req;
      step();
      chk($sformatf("tbl%0d_gnt", v), gnt, tbl[v].gnt);
      chk($sformatf("tbl%0d_rc", v), read_code, tbl[v].rc);
      chk($sformatf("tbl%0d_rvalid", v), rvalid, tbl[v].rvalid);
      chk($sformatf("tbl%0d_rid", v), rid, tbl[v].rid);
      chk($sformatf("tbl%0d_rdata", v), rdata, tbl[v].rdata);
    end

    // Asynchronous reset mid-cycle with mux forced to DEAD
    mux_dead = 1'b1; req = 4'b1111;
    repeat (3) step();
    chk("pre_rst_rdata", rdata, 64'hDEAD);
    req = '0;
    reset = 1'b1;
    #1;
    chk("async_gnt", gnt, 0); chk("async_rc", read_code, 0); chk("async_rvalid", rvalid, 0);
    chk("async_rid", rid, 0); chk("async_rdata", rdata, 0);
    step();
    reset = 1'b0; mux_dead = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("idle_gnt", gnt, 0); chk("idle_rvalid", rvalid, 0);
    end

    // Fairness: all requesters held, pointer starts at 0 after reset
    cnt = '{0, 0, 0, 0};
    req = 4'b1111;
    for (int c = 0; c < 400; c++) begin
      step();
      chk("rr_gnt", gnt, 64'd1 << (c % 4));
      for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
      if (c > 0) begin
        chk("rr_rvalid", rvalid, 1);
        chk("rr_rid", rid, (c - 1) % 4);
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_count%0d", i), cnt[i], 100);
    step(); step();

    // Same-requester mask: alternate grants
    req = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("mask_gnt", gnt, (c % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("mask_rvalid", rvalid, (c % 2 == 1) ? 1 : 0);
    end
    req = '0;
    step(); step();

    // Reset mid-flight: grant to 3, pulse reset, capture must be dropped
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1000;
    step();
    chk("mf_gnt3", gnt, 4'b1000);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    req = 4'b1001;
    step();
    chk("mf_rvalid", rvalid, 0);
    chk("mf_gnt0", gnt, 4'b0001);
    req = '0;
    step();
    chk("mf_rvalid2", rvalid, 1);
    chk("mf_rid2", rid, 0);
    chk("mf_rdata2", rdata, memval(5'd5));

    // Randomized against the reference model
    reset = 1'b1; step(); reset = 1'b0;
    model_init();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      req = 4'($urandom);
      addr = 20'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("rnd_gnt", gnt, (m_gidx < 0) ? 64'd0 : (64'd1 << m_gidx));
      chk("rnd_rc", read_code, m_rc);
      chk("rnd_rvalid", rvalid, m_rvalid);
      chk("rnd_rid", rid, m_rid);
      chk("rnd_rdata", rdata, m_rdata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
